// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter sharing one 4-to-1 single-bit mux among four
// requesters. One requester is granted at a time. A hold quantum of
// HOLD_MAX cycles keeps any one requester from monopolising the mux.
//
// Parameters
//   HOLD_MAX  maximum consecutive grant cycles per tenure (1..255)
//   CNT_W     hold counter width; must be able to represent HOLD_MAX-1
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   req    in   [3:0] level-sensitive request lines, bit i = requester i
//   en     in   arbitration enable; gates new grants only
//   grant  out  [3:0] registered one-hot grant, zero when idle
//   sel1   out  registered MSB of granted index (mux select)
//   sel0   out  registered LSB of granted index (mux select)
//   busy   out  registered, high while a grant is active
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       en,
  output logic [3:0] grant,
  output logic       sel1,
  output logic       sel0,
  output logic       busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q,   ptr_d;
  logic [CNT_W-1:0] hold_q,  hold_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q,   sel_d;
  logic             busy_q,  busy_d;

  logic [1:0] winner;
  logic       any_req;
  logic       release_tenure;

  // Search ptr+1, ptr+2, ptr+3, ptr (mod 4); first asserted request wins.
  // With no request the result is unused.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr,
                                         input logic [3:0] r);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign any_req = |req;
  assign winner  = rr_pick(ptr_q, req);

  // ptr_q always holds the current holder while in GRANT, so the holder's
  // request and the re-arbitration start point come from the same register.
  assign release_tenure = !req[ptr_q] || (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        if (en && any_req) begin
          state_d = GRANT;
          grant_d = 4'b0001 << winner;
          sel_d   = winner;
          busy_d  = 1'b1;
          ptr_d   = winner;
          hold_d  = '0;
        end else begin
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end

      GRANT: begin
        if (!release_tenure) begin
          hold_d = hold_q + CNT_W'(1);
        end else if (en && any_req) begin
          // Handover on the release edge itself: no idle gap. The holder
          // is searched last, so it is re-granted only if nobody else asks.
          grant_d = 4'b0001 << winner;
          sel_d   = winner;
          busy_d  = 1'b1;
          ptr_d   = winner;
          hold_d  = '0;
        end else begin
          // Select lines keep their value so the shared mux output is stable.
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          hold_d  = '0;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      hold_q  <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign sel1  = sel_q[1];
  assign sel0  = sel_q[0];
  assign busy  = busy_q;

  // Output invariants.
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant_q));
  a_busy_matches  : assert property (@(posedge clk) disable iff (!rst_n)
    busy_q == (|grant_q));
  a_sel_matches   : assert property (@(posedge clk) disable iff (!rst_n)
    busy_q |-> grant_q[sel_q]);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       en;
  logic [3:0] grant;
  logic       sel1;
  logic       sel0;
  logic       busy;

  int unsigned checks;
  int unsigned errors;

  mux4_rr_arbiter #(.HOLD_MAX(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (en),
    .grant (grant),
    .sel1  (sel1),
    .sel0  (sel0),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    en    = 1'b0;
    repeat (3) tick();
    checks++;
    if (grant !== 4'b0000) begin
      errors++; $display("FAIL reset_grant got %b want 0000", grant);
    end
    checks++;
    if ({sel1, sel0} !== 2'b00) begin
      errors++; $display("FAIL reset_sel got %b want 00", {sel1, sel0});
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", busy);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle got grant=%b busy=%b want 0000/0", grant, busy);
    end
  endtask

  // From reset ptr=3: all four requesting rotate 0,1,2,3,0 with 8-cycle tenures.
  task automatic test_rotation();
    logic [3:0] exp_g;
    logic [1:0] exp_s;
    req = 4'b1111;
    en  = 1'b1;
    tick();
    for (int t = 0; t < 5; t++) begin
      exp_s = 2'(t % 4);
      exp_g = 4'b0001 << exp_s;
      for (int c = 0; c < 8; c++) begin
        checks++;
        if (grant !== exp_g) begin
          errors++; $display("FAIL rot_grant t=%0d c=%0d got %b want %b", t, c, grant, exp_g);
        end
        checks++;
        if ({sel1, sel0} !== exp_s) begin
          errors++; $display("FAIL rot_sel t=%0d c=%0d got %b want %b", t, c, {sel1, sel0}, exp_s);
        end
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL rot_busy t=%0d c=%0d got %b want 1", t, c, busy);
        end
        tick();
      end
    end
    // Last edge handed over to requester 1.
    checks++;
    if (grant !== 4'b0010) begin
      errors++; $display("FAIL rot_final got %b want 0010", grant);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL rot_idle got grant=%b busy=%b want 0000/0", grant, busy);
    end
  endtask

  // Sole requester 2 keeps the mux across quantum expiries.
  task automatic test_single_holder();
    req = 4'b0100;
    en  = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (grant !== 4'b0100 || busy !== 1'b1) begin
        errors++; $display("FAIL single_grant c=%0d got grant=%b busy=%b want 0100/1", c, grant, busy);
      end
      checks++;
      if ({sel1, sel0} !== 2'b10) begin
        errors++; $display("FAIL single_sel c=%0d got %b want 10", c, {sel1, sel0});
      end
      tick();
    end
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL single_release got grant=%b busy=%b want 0000/0", grant, busy);
    end
    checks++;
    if ({sel1, sel0} !== 2'b10) begin
      errors++; $display("FAIL single_sel_hold got %b want 10", {sel1, sel0});
    end
  endtask

  // Holder 1 drops after 3 cycles; requester 3 takes over on the same edge.
  task automatic test_back_to_back();
    req = 4'b0010;
    en  = 1'b1;
    tick();
    req = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (grant !== 4'b0010) begin
        errors++; $display("FAIL b2b_hold c=%0d got %b want 0010", c, grant);
      end
      if (c < 2) tick();
    end
    req = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b1000 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_handover got grant=%b busy=%b want 1000/1", grant, busy);
    end
    checks++;
    if ({sel1, sel0} !== 2'b11) begin
      errors++; $display("FAIL b2b_sel got %b want 11", {sel1, sel0});
    end
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000) begin
      errors++; $display("FAIL b2b_idle got %b want 0000", grant);
    end
  endtask

  // en low blocks new grants from IDLE; raising it grants requester 0 (ptr=3).
  task automatic test_enable_gate();
    en  = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0) begin
        errors++; $display("FAIL engate_blocked c=%0d got grant=%b busy=%b want 0000/0", c, grant, busy);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0001 || {sel1, sel0} !== 2'b00) begin
      errors++; $display("FAIL engate_grant got grant=%b sel=%b want 0001/00", grant, {sel1, sel0});
    end
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000) begin
      errors++; $display("FAIL engate_idle got %b want 0000", grant);
    end
  endtask

  // en drops during holder 2's tenure: tenure completes, then idle.
  task automatic test_en_drop();
    req = 4'b0100;
    en  = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0100) begin
      errors++; $display("FAIL endrop_start got %b want 0100", grant);
    end
    req = 4'b1111;
    en  = 1'b0;
    for (int c = 1; c < 8; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0100) begin
        errors++; $display("FAIL endrop_hold c=%0d got %b want 0100", c, grant);
      end
    end
    tick();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL endrop_release got grant=%b busy=%b want 0000/0", grant, busy);
    end
    tick();
    checks++;
    if (grant !== 4'b0000) begin
      errors++; $display("FAIL endrop_stay got %b want 0000", grant);
    end
    req = 4'b0000;
  endtask

  // Reset asserted between edges clears outputs immediately.
  task automatic test_async_reset();
    req = 4'b0100;
    en  = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0100 || {sel1, sel0} !== 2'b10) begin
      errors++; $display("FAIL areset_pre got grant=%b sel=%b want 0100/10", grant, {sel1, sel0});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000 || {sel1, sel0} !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL areset_now got grant=%b sel=%b busy=%b want 0000/00/0", grant, {sel1, sel0}, busy);
    end
    tick();
    rst_n = 1'b1;
    req   = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b1000 || {sel1, sel0} !== 2'b11 || busy !== 1'b1) begin
      errors++; $display("FAIL areset_after got grant=%b sel=%b busy=%b want 1000/11/1", grant, {sel1, sel0}, busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_rotation();
    test_single_holder();
    test_back_to_back();
    test_enable_gate();
    test_en_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4-to-1 single-bit mux between four requesters. It accepts per-requester requests and grants exactly one requester at a time. It drives the mux select pair (sel1, sel0) and one-hot grant lines. A hold quantum keeps any one requester from monopolising the mux.

## Interface
- HOLD_MAX, 8: maximum consecutive grant cycles per tenure; legal range 1..255.
- CNT_W, 8: width of the hold counter; must hold HOLD_MAX-1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset. One clock domain only.
- req  input  4  request lines; bit i is requester i, level-sensitive.
- en  input  1  arbitration enable. When low, no new grant is issued and the current tenure runs to its normal release.
- grant  output  4  registered one-hot grant; all zero when idle.
- sel1  output  1  registered MSB of the granted index, for the mux select.
- sel0  output  1  registered LSB of the granted index, for the mux select.
- busy  output  1  registered; high while any grant is active.

## Operation
- State machine with two states, IDLE and GRANT.
- Priority pointer ptr (2 bits) holds the index of the last granted requester.
  - Search order is ptr+1, ptr+2, ptr+3, ptr, all modulo 4.
  - The first requester found with req high wins.
- IDLE:
  - If en=1 and req≠0, pick a winner w.
  - Next state is GRANT. Set grant=1<<w, {sel1,sel0}=w, busy=1, ptr=w, hold_cnt=0.
  - Otherwise stay in IDLE. grant=0 and busy=0; {sel1,sel0} keep their last value so the mux output stays stable.
- GRANT, holder h:
  - Release condition: req[h]=0, or hold_cnt==HOLD_MAX-1.
  - No release: hold_cnt increments and all outputs are unchanged.
  - On release with en=1 and any req bit high (req[h] included), re-arbitrate from ptr=h.
    - The new winner is granted on the same edge, with hold_cnt=0 and no idle gap.
    - If h is the only requester still requesting after quantum expiry, h is re-granted.
  - On release with en=0, or with req==0: go to IDLE with grant=0 and busy=0.
- Raising or lowering en has no effect on a tenure in progress.
- Reset values: state=IDLE, grant=4'b0000, sel1=0, sel0=0, busy=0, ptr=3 (requester 0 has first priority), hold_cnt=0.
- Reset asserted mid-tenure clears everything immediately, without waiting for a clock edge.
- Invariants:
  - grant is always zero-hot or one-hot.
  - {sel1,sel0} equals the index of the set grant bit whenever busy=1.
  - busy equals |grant.

## Timing
- Request to grant latency:
  - A request sampled at edge N while IDLE gives grant at edge N, visible in cycle N+1. That is one cycle of latency.
- Release and handover:
  - Holder drops req before edge N: grant moves to the next requester, or clears, at edge N.
  - There are no dead cycles between back-to-back tenures.
- Maximum tenure is HOLD_MAX cycles. With HOLD_MAX=1, the grant rotates every cycle among the active requesters.
- Simultaneous events:
  - Holder deasserts in the same cycle as quantum expiry: treated as a single release, one re-arbitration.
  - All four requesting: grants rotate strictly in the order ptr+1, ptr+2, ptr+3, ptr.
- Worst-case wait for a continuously requesting requester is 3×HOLD_MAX cycles plus 1.
- rst_n deassertion is synchronised externally. The first arbitration happens at the first edge after release.

## Test plan
- Reset, then req=4'b1111 with en=1. Next cycle grant=0001 and sel=00. Grants then rotate 0001→0010→0100→1000→0001, each held 8 cycles. busy stays high with no gaps.
- req=4'b0100 only, held high for 20 cycles with HOLD_MAX=8:
  - grant=0100 with sel1=1 and sel0=0 throughout; hold_cnt wraps at 7 and 15 with no drop.
  - After req falls, grant=0000 and busy=0. {sel1,sel0} stays 10.
- Holder 1 drops its req after 3 cycles while req[3]=1. grant goes 0010→1000 on the same edge, with no idle cycle.
- en=0 with req=1111 from IDLE: grant stays 0000. Then en=1: grant=0001 one cycle later.
- Drop en while holder 2 is active: holder 2 finishes its tenure, then grant=0000 even though other requests are pending.
- Assert rst_n=0 mid-tenure between clock edges. grant=0000, sel=00 and busy=0 take effect immediately. After release, req=1000 gives grant=1000.
